// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) constant multiplies and the mixcol_seq FSM state type.
// The inverse-coefficient multipliers exist only when MIXCOL_SEQ_INV_EN is defined.
package aes_pkg;

  localparam logic [7:0] AES_RED_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_RED_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] x);
    return xtime(x);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

`ifdef MIXCOL_SEQ_INV_EN
  // 9, 11, 13, 14 built from x*8, x*4, x*2 partial products.
  function automatic logic [7:0] mul9(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction
`endif

endpackage

// File: rtl/mixcol_column.sv
// One-column (Inv)MixColumns multiplier, purely combinational, zero latency.
// Inverse select port exists only under MIXCOL_SEQ_INV_EN; no handshake of its own.
module mixcol_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
`ifdef MIXCOL_SEQ_INV_EN
  input  logic        inv_i,
`endif
  output logic [31:0] col_o
);

  logic [7:0]  a0, a1, a2, a3;
  logic [31:0] fwd_col;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign fwd_col = {mul2(a0) ^ mul3(a1) ^ a2 ^ a3,
                    a0 ^ mul2(a1) ^ mul3(a2) ^ a3,
                    a0 ^ a1 ^ mul2(a2) ^ mul3(a3),
                    mul3(a0) ^ a1 ^ a2 ^ mul2(a3)};

`ifdef MIXCOL_SEQ_INV_EN
  logic [31:0] inv_col;

  assign inv_col = {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
                    mul9(a0) ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
                    mul13(a0) ^ mul9(a1) ^ mul14(a2) ^ mul11(a3),
                    mul11(a0) ^ mul13(a1) ^ mul9(a2) ^ mul14(a3)};

  assign col_o = inv_i ? inv_col : fwd_col;
`else
  assign col_o = fwd_col;
`endif

endmodule

// File: rtl/mixcol_seq.sv
// Iterative AES MixColumns, one column per clock: 4 cycles acceptance-to-out_valid; result held
// stable until out_ready, no new input accepted meanwhile. MIXCOL_SEQ_INV_EN adds the inv port.
module mixcol_seq
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef MIXCOL_SEQ_INV_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  mc_state_t        state_q;
  logic [1:0]       col_q;
  logic [3:0][31:0] work_q;   // work_q[3] is column 0 (top bits)
  logic             in_ready_q;
  logic             out_valid_q;
  logic [1:0]       col_idx;
  logic [31:0]      col_d;

  assign col_idx = 2'd3 - col_q;

`ifdef MIXCOL_SEQ_INV_EN
  logic inv_q;

  mixcol_column u_column (
    .col_i (work_q[col_idx]),
    .inv_i (inv_q),
    .col_o (col_d)
  );
`else
  mixcol_column u_column (
    .col_i (work_q[col_idx]),
    .col_o (col_d)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef MIXCOL_SEQ_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q     <= in_data;
            col_q      <= 2'd0;
            state_q    <= CALC;
            in_ready_q <= 1'b0;
`ifdef MIXCOL_SEQ_INV_EN
            inv_q      <= inv;
`endif
          end
        end
        CALC: begin
          work_q[col_idx] <= col_d;
          col_q           <= col_q + 2'd1;
          if (col_q == 2'd3) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = work_q;

endmodule

// File: tb/tb_mixcol_seq.sv
// Directed bench for mixcol_seq: FIPS-197 vectors, stall, streaming, abort-by-reset,
// and (with MIXCOL_SEQ_INV_EN) inverse vectors plus forward/inverse round trips.
module tb_mixcol_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
`ifdef MIXCOL_SEQ_INV_EN
  logic         inv = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mixcol_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef MIXCOL_SEQ_INV_EN
    .inv       (inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Shift-and-add GF(2^8) multiply, independent of the RTL's fixed-constant helpers.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s, input bit iv);
    logic [7:0]   cf [4];
    logic [7:0]   a  [4];
    logic [7:0]   b;
    logic [127:0] r;
    if (iv) begin
      cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    end else begin
      cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gmul(a[j], cf[(j - rr + 4) % 4]);
        r[127-8*(4*c+rr) -: 8] = b;
      end
    end
    return r;
  endfunction

  // Present one block, wait for acceptance, then count edges until out_valid.
  task automatic xfer(input logic [127:0] d, output logic [127:0] res, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("in_ready_wait", {127'b0, in_ready}, 128'd1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_data;
  endtask

  task automatic pop(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, {127'b0, in_ready}, 128'd1);
    check({tag, "_out_valid_after"}, {127'b0, out_valid}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res;
    logic [127:0] mid;
    logic [127:0] st;
    logic [127:0] blk [8];
    logic [127:0] expv [8];
    int           acc_cyc [8];
    int           lat;
    int           idx;
    int           nout;
    int           cyc;
    int           seen;
    bit           acc_now;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {127'b0, in_ready}, 128'd1);
    check("rst_out_valid", {127'b0, out_valid}, 128'd0);
    check("rst_out_data", out_data, 128'd0);
    rst = 1'b0;

    // FIPS-197 example state.
    xfer(128'hdb135345_f20a225c_01010101_c6c6c6c6, res, lat);
    check("fips_latency", lat, 128'd4);
    check("fips_data", res, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    pop("fips");

    // Ten-cycle stall, with a competing input offered that must be ignored.
    xfer(128'hd4d4d4d5_2d26314c_00000000_ffffffff, res, lat);
    check("stall_latency", lat, 128'd4);
    in_data  = 128'h11111111_22222222_33333333_44444444;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("stall_data", out_data, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);
      check("stall_in_ready", {127'b0, in_ready}, 128'd0);
      check("stall_out_valid", {127'b0, out_valid}, 128'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stall_data_end", out_data, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);
    pop("stall");

    // Streaming with both handshakes held high.
    for (int i = 0; i < 8; i++) begin
      blk[i]  = {$urandom, $urandom, $urandom, $urandom};
      expv[i] = mix_model(blk[i], 1'b0);
    end
    idx = 0;
    nout = 0;
    cyc = 0;
    in_data = blk[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (nout < 8 && cyc < 300) begin
      acc_now = in_ready && in_valid;
      if (out_valid) begin
        check("stream_data", out_data, expv[nout]);
        nout++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc_now) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 8) in_data = blk[idx];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("stream_count", nout, 128'd8);
    check("stream_accepts", idx, 128'd8);
    // Accept edge, 4 column edges, output edge, one idle cycle before the next accept.
    for (int i = 1; i < 8; i++)
      if (i < idx) check("stream_gap", acc_cyc[i] - acc_cyc[i-1], 128'd6);

    // Reset two cycles after acceptance aborts the block.
    @(posedge clk); #1;
    in_data  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", {127'b0, in_ready}, 128'd1);
    check("abort_out_valid", {127'b0, out_valid}, 128'd0);
    check("abort_out_data", out_data, 128'd0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_output", seen, 128'd0);

    xfer(128'hd4d4d4d5_2d26314c_00000000_ffffffff, res, lat);
    check("recover_latency", lat, 128'd4);
    check("recover_data", res, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);
    pop("recover");

`ifdef MIXCOL_SEQ_INV_EN
    inv = 1'b1;
    xfer(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, res, lat);
    check("inv_latency", lat, 128'd4);
    check("inv_data", res, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
    pop("inv");

    for (int i = 0; i < 16; i++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'b0;
      xfer(st, mid, lat);
      pop("rt_fwd");
      check("rt_fwd_data", mid, mix_model(st, 1'b0));
      inv = 1'b1;
      xfer(mid, res, lat);
      pop("rt_inv");
      check("rt_roundtrip", res, st);
    end
    inv = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
